fetch_queue: RTL and testbench

Parametrised fetch stage for the five-stage core. It replaces the free-running PC counter plus direct imem hookup with a request/response imem interface, an in-order instruction queue of DEPTH entries, and a valid/ready handoff to decode. Redirects from execute (taken branch/jump) flush the queue and discard stale in-flight responses. It sits between imemory and the decode/control stage.

---
 rtl/fetch_queue.sv | 130 +++++++++++++
 tb/tb_fetch_queue.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
// fetch_queue
// Fetch stage: issues word-aligned fetch requests to imem and buffers the
// in-order responses in a DEPTH-entry circular queue with their PCs. The
// queue hands instructions to decode over a valid/ready interface. A redirect
// from execute flushes the queue, restarts fetch at the new PC, and marks
// every still-in-flight response to be dropped on arrival.
//
// Optional build macro:
//   FETCH_BYPASS_EN  a live response that arrives while the queue is empty is
//                    shown on dec_* in the same cycle. It skips the queue if
//                    decode takes it.
//
// Ports:
//   clock, reset          rising-edge clock, async active-low reset
//   imem_req_valid/addr   fetch request (combinational), imem_req_ready accept
//   imem_rsp_valid/data   in-order instruction responses
//   redirect_valid/pc     flush and restart fetch at redirect_pc & ~3
//   dec_valid/pc/inst     queue head to decode, dec_ready consumes it
//   count                 queue occupancy
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0100_0000
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       imem_req_valid,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_req_ready,
  input  logic                       imem_rsp_valid,
  input  logic [31:0]                imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       dec_valid,
  output logic [XLEN-1:0]            dec_pc,
  output logic [31:0]                dec_inst,
  input  logic                       dec_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic            started;      // low in the first cycle after reset release
  logic [XLEN-1:0] fetch_pc, rsp_pc, last_pc;
  logic [31:0]     last_inst;
  logic [CW-1:0]   outstanding, drop_cnt, live;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic            q_empty, accept, rsp_live, byp, push, pop;

  assign live    = outstanding - drop_cnt;
  assign q_empty = (count == '0);

  // Credit check: every live in-flight request already owns a queue slot,
  // so an arriving live response can never find the queue full.
  assign imem_req_valid = started && !redirect_valid && (drop_cnt == '0) &&
                          (({1'b0, count} + {1'b0, live}) < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // A response belongs to the current stream only when nothing is owed to
  // the drop counter and no redirect is being taken this cycle.
  assign rsp_live = started && imem_rsp_valid && !redirect_valid && (drop_cnt == '0);

`ifdef FETCH_BYPASS_EN
  assign byp = rsp_live && q_empty;
`else
  assign byp = 1'b0;
`endif

  // When empty (and not bypassing), dec_pc/dec_inst replay the last head
  // that was shown, so they stay stable rather than exposing a stale slot.
  assign dec_valid = !q_empty || byp;
  assign dec_pc    = !q_empty ? pc_mem[rd_ptr]   : (byp ? rsp_pc        : last_pc);
  assign dec_inst  = !q_empty ? inst_mem[rd_ptr] : (byp ? imem_rsp_data : last_inst);

  assign pop  = !q_empty && dec_ready && !redirect_valid;
  assign push = rsp_live && !(byp && dec_ready);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      started     <= 1'b0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      last_pc     <= '0;
      last_inst   <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      started <= 1'b1;
      if (dec_valid) begin
        last_pc   <= dec_pc;
        last_inst <= dec_inst;
      end
      if (redirect_valid) begin
        // A response landing this cycle retires one of the outstanding
        // requests itself; every remaining one is stale and must be dropped.
        fetch_pc    <= redirect_pc & ~XLEN'(3);
        rsp_pc      <= redirect_pc & ~XLEN'(3);
        outstanding <= outstanding - CW'(imem_rsp_valid);
        drop_cnt    <= outstanding - CW'(imem_rsp_valid);
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        count       <= '0;
      end else begin
        if (accept)   fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_live) rsp_pc   <= rsp_pc + XLEN'(4);
        outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Queue storage needs no reset: count gates every read of it.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr]   <= rsp_pc;
      inst_mem[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
module tb_fetch_queue;
  localparam logic [31:0] RPC = 32'h0100_0000;
  localparam logic [31:0] K   = 32'h5A5A_5A5A;  // imem model: inst = addr ^ K
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
  localparam int T1_POPS = 18;
`else
  localparam int LAT = 2;
  localparam int T1_POPS = 17;
`endif

  logic        clock, reset;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_pc, dec_inst;
  logic [2:0]  count;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_inst(dec_inst),
    .dec_ready(dec_ready), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_acc, first_dv, pend_at_acc;
  logic rsp_en;
  logic [31:0] pend_addr[$];
  int          pend_cyc[$];
  logic [31:0] acc_log[$], pop_log[$], pop_inst[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    acc_log.delete(); pop_log.delete(); pop_inst.delete();
    first_acc = -1; first_dv = -1; pend_at_acc = -1;
  endtask

  // imem model: answers in order, one cycle after acceptance at the earliest.
  task automatic drive();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (rsp_en && pend_addr.size() > 0 && pend_cyc[0] < cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend_addr[0] ^ K;
    end
    #1;
  endtask

  task automatic finish_cyc();
    if (count > 3'd4) chk("overflow", 64'(count), 64'd4);
    if (imem_rsp_valid) begin
      void'(pend_addr.pop_front());
      void'(pend_cyc.pop_front());
    end
    if (imem_req_valid && imem_req_ready) begin
      if (first_acc < 0) begin
        first_acc   = cyc;
        pend_at_acc = pend_addr.size();
      end
      acc_log.push_back(imem_req_addr);
      pend_addr.push_back(imem_req_addr);
      pend_cyc.push_back(cyc);
    end
    if (dec_valid && first_dv < 0) first_dv = cyc;
    if (dec_valid && dec_ready && !redirect_valid) begin
      pop_log.push_back(dec_pc);
      pop_inst.push_back(dec_inst);
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic step();
    drive();
    finish_cyc();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0;
    pend_addr.delete(); pend_cyc.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    clear_logs();
  endtask

  initial begin
    reset = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0; rsp_en = 1'b1;
    clear_logs();

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_dec_pc", 64'(dec_pc), 64'd0);
    chk("rst_dec_inst", 64'(dec_inst), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // T1: streaming, 1-cycle imem, decode always ready
    dec_ready = 1'b1;
    clear_logs();
    repeat (20) step();
    chk("t1_latency", 64'(first_dv - first_acc), 64'(LAT));
    chk("t1_pops", 64'(pop_log.size()), 64'(T1_POPS));
    for (int i = 0; i < 6; i++) begin
      chk("t1_req_addr", 64'(acc_log[i]), 64'(RPC + 32'(4*i)));
      chk("t1_dec_pc", 64'(pop_log[i]), 64'(RPC + 32'(4*i)));
      chk("t1_dec_inst", 64'(pop_inst[i]), 64'((RPC + 32'(4*i)) ^ K));
    end

    // T2: decode stalled fills the queue; one pop frees one request slot
    do_reset();
    dec_ready = 1'b0;
    repeat (10) step();
    chk("t2_accepts", 64'(acc_log.size()), 64'd4);
    chk("t2_count", 64'(count), 64'd4);
    chk("t2_req_valid", 64'(imem_req_valid), 64'd0);
    chk("t2_dec_pc", 64'(dec_pc), 64'(RPC));
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    repeat (5) step();
    chk("t2_accepts_after", 64'(acc_log.size()), 64'd5);
    chk("t2_last_req", 64'(acc_log[4]), 64'(RPC + 32'd16));
    chk("t2_count_after", 64'(count), 64'd4);
    chk("t2_dec_pc_after", 64'(dec_pc), 64'(RPC + 32'd4));

    // T3: redirect with 2 queued and 2 in flight
    do_reset();
    dec_ready = 1'b0;
    for (int i = 0; i < 20 && count != 3'd2; i++) step();
    chk("t3_fill", 64'(count), 64'd2);
    rsp_en = 1'b0;
    repeat (5) step();
    chk("t3_accepts", 64'(acc_log.size()), 64'd4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_0102;
    drive();
    chk("t3_req_in_redirect", 64'(imem_req_valid), 64'd0);
    finish_cyc();
    redirect_valid = 1'b0;
    drive();
    chk("t3_flush_count", 64'(count), 64'd0);
    chk("t3_flush_dec_valid", 64'(dec_valid), 64'd0);
    chk("t3_req_while_drop", 64'(imem_req_valid), 64'd0);
    chk("t3_hold_dec_pc", 64'(dec_pc), 64'(RPC));
    finish_cyc();
    clear_logs();
    rsp_en = 1'b1;
    dec_ready = 1'b1;
    repeat (12) step();
    chk("t3_first_req", 64'(acc_log[0]), 64'h0100_0100);
    chk("t3_no_req_during_drop", 64'(pend_at_acc), 64'd0);
    chk("t3_first_pc", 64'(pop_log[0]), 64'h0100_0100);
    chk("t3_second_pc", 64'(pop_log[1]), 64'h0100_0104);
    chk("t3_first_inst", 64'(pop_inst[0]), 64'(32'h0100_0100 ^ K));

    // T4: redirect coinciding with a response and a pop, outstanding=1
    do_reset();
    dec_ready = 1'b0;
    for (int i = 0; i < 20 && acc_log.size() < 3; i++) step();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 10 && count != 3'd3; i++) step();
    chk("t4_fill", 64'(count), 64'd3);
    imem_req_ready = 1'b1;
    drive();
    chk("t4_req_valid", 64'(imem_req_valid), 64'd1);
    finish_cyc();
    clear_logs();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0200_0000;
    dec_ready      = 1'b1;
    drive();
    chk("t4_rsp_present", 64'(imem_rsp_valid), 64'd1);
    chk("t4_req_in_redirect", 64'(imem_req_valid), 64'd0);
    finish_cyc();
    redirect_valid = 1'b0;
    dec_ready      = 1'b0;
    drive();
    chk("t4_count", 64'(count), 64'd0);
    chk("t4_dec_valid", 64'(dec_valid), 64'd0);
    chk("t4_req_next", 64'(imem_req_valid), 64'd1);
    chk("t4_req_addr", 64'(imem_req_addr), 64'h0200_0000);
    chk("t4_pop_ignored", 64'(pop_log.size()), 64'd0);
    finish_cyc();

    // T5: address wrap past the top of the address space
    dec_ready = 1'b1;
    repeat (3) step();
    clear_logs();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    repeat (10) step();
    chk("t5_req0", 64'(acc_log[0]), 64'hFFFF_FFF8);
    chk("t5_req1", 64'(acc_log[1]), 64'hFFFF_FFFC);
    chk("t5_req2", 64'(acc_log[2]), 64'h0000_0000);
    chk("t5_req3", 64'(acc_log[3]), 64'h0000_0004);
    chk("t5_pc1", 64'(pop_log[1]), 64'hFFFF_FFFC);
    chk("t5_pc2", 64'(pop_log[2]), 64'h0000_0000);
    chk("t5_pc3", 64'(pop_log[3]), 64'h0000_0004);

    // T6: asynchronous reset with a full queue
    dec_ready = 1'b0;
    for (int i = 0; i < 20 && count != 3'd4; i++) step();
    chk("t6_full", 64'(count), 64'd4);
    reset = 1'b0;
    #1;
    chk("t6_req_valid", 64'(imem_req_valid), 64'd0);
    chk("t6_dec_valid", 64'(dec_valid), 64'd0);
    chk("t6_dec_pc", 64'(dec_pc), 64'd0);
    chk("t6_dec_inst", 64'(dec_inst), 64'd0);
    chk("t6_count", 64'(count), 64'd0);
    imem_rsp_valid = 1'b0;
    pend_addr.delete(); pend_cyc.delete();
    @(negedge clock);
    reset = 1'b1;
    clear_logs();
    dec_ready = 1'b1;
    repeat (8) step();
    chk("t6_refetch", 64'(acc_log[0]), 64'(RPC));
    chk("t6_first_pc", 64'(pop_log[0]), 64'(RPC));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
